// File: rtl/mantle_split3_stream_deser.sv
`default_nettype none
// ============================================================================
// Module      : mantle_split3_stream_deser
// Description : Frames a serial valid/ready word stream into packets of
//               N0+N1+N2 words and presents each packet as three parallel
//               output arrays (segment 0, 1 and 2). Flags short and long
//               packets with a one-cycle err_len pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mantle_split3_stream_deser #(
    parameter int WIDTH = 32,
    parameter int N0    = 9,
    parameter int N1    = 6,
    parameter int N2    = 7
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0 [N0],
    output logic [WIDTH-1:0] out1 [N1],
    output logic [WIDTH-1:0] out2 [N2],
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_len
);

    localparam int TOTAL = N0 + N1 + N2;
    localparam int CW    = $clog2(TOTAL + 1);

    localparam logic [CW-1:0] C_LAST_IDX = CW'(TOTAL - 1);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          err_q,   err_d;
    logic          accept_w;

    // Ready only while filling; reset forces it low immediately.
    assign in_ready = (state_q == S_FILL) && !ASYNCRESET;
    assign accept_w = in_valid && in_ready;

    assign out_valid = (state_q == S_HOLD);
    assign err_len   = err_q;

    // Next-state, word counter and framing-error decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            S_FILL: begin
                if (accept_w) begin
                    if (cnt_q == C_LAST_IDX) begin
                        // Packet is full; a missing in_last marks a long packet
                        // but the data is still delivered.
                        state_d = S_HOLD;
                        cnt_d   = '0;
                        err_d   = !in_last;
                    end else if (in_last) begin
                        // Short packet: drop partial data, restart framing.
                        cnt_d = '0;
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
                cnt_d   = '0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Segment 0 elements: packet words 0..N0-1.
    for (genvar k = 0; k < N0; k++) begin : g_seg0
        always_ff @(posedge CLK or posedge ASYNCRESET) begin
            if (ASYNCRESET) begin
                out0[k] <= '0;
            end else if (accept_w && (cnt_q == CW'(k))) begin
                out0[k] <= in_data;
            end
        end
    end

    // Segment 1 elements: packet words N0..N0+N1-1.
    for (genvar k = 0; k < N1; k++) begin : g_seg1
        always_ff @(posedge CLK or posedge ASYNCRESET) begin
            if (ASYNCRESET) begin
                out1[k] <= '0;
            end else if (accept_w && (cnt_q == CW'(N0 + k))) begin
                out1[k] <= in_data;
            end
        end
    end

    // Segment 2 elements: packet words N0+N1..TOTAL-1.
    for (genvar k = 0; k < N2; k++) begin : g_seg2
        always_ff @(posedge CLK or posedge ASYNCRESET) begin
            if (ASYNCRESET) begin
                out2[k] <= '0;
            end else if (accept_w && (cnt_q == CW'(N0 + N1 + k))) begin
                out2[k] <= in_data;
            end
        end
    end

endmodule
`default_nettype wire
